// File: rtl/aes_inv_keyexpansion_256.sv
// -----------------------------------------------------------------------------
// aes_inv_keyexpansion_256
//   Reverse-direction AES-256 key schedule. Given the last two round keys of a
//   forward expansion (rk13:rk14 = words w52..w59) it walks the FIPS-197
//   recurrence backward and presents rk14, rk13, ... rk0, one per cycle, in the
//   order the inverse cipher consumes them.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   start      begin a run (sampled only while idle)
//   last_key   {w52..w59}; w52 in [255:224], w59 in [31:0]
//   hold       freeze the sequence while high (running only)
//   subkey     round key currently presented {w4r, w4r+1, w4r+2, w4r+3}
//   round_idx  round number r of subkey (14..0)
//   rdy        subkey / round_idx valid
//   done       high while the round-0 key is presented
// -----------------------------------------------------------------------------
module aes_inv_keyexpansion_256 (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] last_key,
  input  logic         hold,
  output logic [127:0] subkey,
  output logic [3:0]   round_idx,
  output logic         rdy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Forward AES S-box, element 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Round constant for the given index (1..7); other indices never reach g0.
  function automatic logic [7:0] rcon(input logic [2:0] n);
    logic [7:0] rc;
    case (n)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   a_q, a_d;    // next-lower round key (rk cnt-1)
  logic [127:0]   b_q, b_d;    // key being presented (rk cnt)
  logic [3:0]     cnt_q, cnt_d;

  // Backward step: rk(cnt-2) from A = rk(cnt-1) and B = rk(cnt).
  // Undoing w[i] = w[i-8] ^ t(w[i-1]) for the four words of B; the word
  // preceding B word 0 is A word 3, the others precede inside B itself, so
  // all four words come straight from registers with no chaining.
  logic [31:0]  a3, b0, b1, b2, b3, g0;
  logic [127:0] c;

  always_comb begin
    a3 = a_q[31:0];
    b0 = b_q[127:96];
    b1 = b_q[95:64];
    b2 = b_q[63:32];
    b3 = b_q[31:0];
    // w[i] with i = 4*cnt: i is a multiple of 8 when cnt is even.
    if (cnt_q[0]) g0 = sub_word(a3);
    else          g0 = sub_word({a3[23:0], a3[31:24]}) ^ {rcon(cnt_q[3:1]), 24'h0};
    c = {b0 ^ g0, b1 ^ b0, b2 ^ b1, b3 ^ b2};
  end

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = last_key[255:128];
          b_d     = last_key[127:0];
          cnt_d   = 4'd14;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (cnt_q == 4'd0) begin
            // Clearing on exit keeps every output at zero while idle.
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            b_d   = a_q;
            a_d   = c;
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign subkey    = b_q;
  assign round_idx = cnt_q;
  assign rdy       = (state_q == RUN);
  assign done      = (state_q == RUN) && (cnt_q == 4'd0);

endmodule

// File: tb/tb_aes_inv_keyexpansion_256.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_keyexpansion_256
//   Directed bench for the reverse AES-256 key schedule. A forward key
//   expander builds rk0..rk14 from a cipher key; rk13:rk14 feed the DUT and
//   the presented keys are compared with the forward result in reverse order.
//   Fixed anchors for key 000102..1f pin the expander itself.
// -----------------------------------------------------------------------------
module tb_aes_inv_keyexpansion_256;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] last_key;
  logic         hold;
  logic [127:0] subkey;
  logic [3:0]   round_idx;
  logic         rdy;
  logic         done;

  aes_inv_keyexpansion_256 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_key  (last_key),
    .hold      (hold),
    .subkey    (subkey),
    .round_idx (round_idx),
    .rdy       (rdy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [127:0] rk  [15];   // forward-expanded round keys of the current key
  logic [127:0] got [15];   // keys captured from the DUT, indexed by round

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Forward FIPS-197 AES-256 expansion into rk[0..14].
  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Accept one run from idle, follow it to the end, then check it went idle.
  task automatic run_and_check(input string tag, input logic [255:0] key, input bit full);
    expand(key);
    last_key = {rk[13], rk[14]};
    start    = 1'b1;
    step();
    start    = 1'b0;
    last_key = ~last_key;   // must not disturb the run in flight
    for (int r = 14; r >= 0; r--) begin
      check({tag, "_subkey"}, subkey, rk[r]);
      check({tag, "_round_idx"}, 128'(round_idx), 128'(r));
      if (full) begin
        check({tag, "_rdy"}, 128'(rdy), 128'd1);
        check({tag, "_done"}, 128'(done), (r == 0) ? 128'd1 : 128'd0);
      end else begin
        check({tag, "_no_x"}, 128'($isunknown({subkey, round_idx, rdy, done})), 128'd0);
      end
      got[r] = subkey;
      step();
    end
    check({tag, "_end_rdy"}, 128'(rdy), 128'd0);
    check({tag, "_end_subkey"}, subkey, 128'd0);
    if (full) begin
      check({tag, "_end_done"}, 128'(done), 128'd0);
      check({tag, "_end_round_idx"}, 128'(round_idx), 128'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [255:0] key;
    logic [127:0] anchor;
    int           hold_n;
    int           done_cycles;
    int           k16;

    reset    = 1'b1;
    start    = 1'b0;
    hold     = 1'b0;
    last_key = '0;

    // Reset state; hold and start with reset asserted change nothing.
    step();
    hold = 1'b1;
    step();
    check("rst_subkey", subkey, 128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd0);
    check("rst_rdy", 128'(rdy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    reset = 1'b0;
    step();
    check("idle_hold_ignored_rdy", 128'(rdy), 128'd0);
    hold = 1'b0;

    // Key 000102..1f, no hold.
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_and_check("k0", key, 1'b1);
    anchor = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    check("k0_rk14_anchor", got[14], anchor);
    anchor = 128'h101112131415161718191a1b1c1d1e1f;
    check("k0_rk1_anchor", got[1], anchor);
    anchor = 128'h000102030405060708090a0b0c0d0e0f;
    check("k0_rk0_anchor", got[0], anchor);

    // FIPS-197 A.3 key loopback: rk0:rk1 reproduces the cipher key.
    key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run_and_check("a3", key, 1'b1);
    check("a3_rk0_rk1_hi", got[0], key[255:128]);
    check("a3_rk0_rk1_lo", got[1], key[127:0]);

    // Holds: 1 cycle at r=14, 3 at r=7, 2 at r=0.
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    expand(key);
    last_key = {rk[13], rk[14]};
    start = 1'b1;
    step();
    start = 1'b0;
    done_cycles = 0;
    for (int r = 14; r >= 0; r--) begin
      hold_n = (r == 14) ? 1 : (r == 7) ? 3 : (r == 0) ? 2 : 0;
      for (int h = 0; h <= hold_n; h++) begin
        check("hold_subkey", subkey, rk[r]);
        check("hold_round_idx", 128'(round_idx), 128'(r));
        check("hold_rdy", 128'(rdy), 128'd1);
        if (done === 1'b1) done_cycles++;
        hold = (h < hold_n);
        step();
      end
    end
    hold = 1'b0;
    check("hold_done_cycles", 128'(done_cycles), 128'd3);
    check("hold_end_rdy", 128'(rdy), 128'd0);

    // Reset while round 9 is presented aborts the run.
    last_key = {rk[13], rk[14]};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_round_idx_before", 128'(round_idx), 128'd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_rdy", 128'(rdy), 128'd0);
    check("abort_subkey", subkey, 128'd0);
    check("abort_round_idx", 128'(round_idx), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    // start together with reset: reset wins.
    start = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("start_reset_rdy", 128'(rdy), 128'd0);
    step();
    start = 1'b0;
    check("restart_subkey", subkey, rk[14]);
    check("restart_round_idx", 128'(round_idx), 128'd14);
    for (int i = 0; i < 20; i++) begin
      if (rdy !== 1'b1) break;
      step();
    end
    check("restart_drain_rdy", 128'(rdy), 128'd0);

    // start held for 40 cycles: a new run is accepted one idle cycle after
    // each run ends, so rdy is low on every 16th cycle only.
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      k16 = k % 16;
      check("cont_rdy", 128'(rdy), (k16 != 0) ? 128'd1 : 128'd0);
      if (k16 != 0) begin
        check("cont_round_idx", 128'(round_idx), 128'(15 - k16));
        check("cont_subkey", subkey, rk[15 - k16]);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy !== 1'b1) break;
      step();
    end
    check("cont_drain_rdy", 128'(rdy), 128'd0);

    // Random keys.
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      run_and_check("rand", key, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
